// File: rtl/bf16_mul_pipe3_pkg.sv
// Shared widths, constants and pipeline payload types for the bf16 multiplier.
// Also holds the stage-1 unpack/classify helper used by the top.
package bf16_mul_pipe3_pkg;

  localparam int DW     = 16;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 7;
  localparam int BIAS   = 127;
  localparam int SEXP_W = 10;

  localparam logic [DW-1:0] QNAN = 16'h7FC0;
  localparam logic [DW-1:0] INF  = 16'h7F80;

  typedef struct packed {
    logic              vld;
    logic              sign;
    logic [SEXP_W-1:0] exp;
    logic [MAN_W:0]    man_a;
    logic [MAN_W:0]    man_b;
    logic              nan;
    logic              inf;
    logic              zero;
  } s1_t;

  typedef struct packed {
    logic                vld;
    logic                sign;
    logic [SEXP_W-1:0]   exp;
    logic [2*MAN_W+1:0]  prod;
    logic                nan;
    logic                inf;
    logic                zero;
  } s2_t;

  // Exponent 0 covers both true zero and subnormals, which are flushed.
  function automatic s1_t unpack(input logic vld, input logic [DW-1:0] a, input logic [DW-1:0] b);
    s1_t              s;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] ma;
    logic [MAN_W-1:0] mb;
    logic             a_inf;
    logic             b_inf;
    logic             a_zero;
    logic             b_zero;
    ea     = a[DW-2 -: EXP_W];
    eb     = b[DW-2 -: EXP_W];
    ma     = a[MAN_W-1:0];
    mb     = b[MAN_W-1:0];
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    s       = '0;
    s.vld   = vld;
    s.sign  = a[DW-1] ^ b[DW-1];
    s.exp   = {2'b00, ea} + {2'b00, eb} - SEXP_W'(BIAS);
    s.man_a = {1'b1, ma};
    s.man_b = {1'b1, mb};
    s.nan   = ((ea == '1) && (ma != '0)) || ((eb == '1) && (mb != '0)) ||
              (a_inf && b_zero) || (b_inf && a_zero);
    s.inf   = a_inf || b_inf;
    s.zero  = a_zero || b_zero;
    return s;
  endfunction

endpackage

// File: rtl/bf16_mul_pipe3_if.sv
// Operand/result bus for the bf16 multiplier; master is the source/sink side.
// The sink samples z whenever s_output_z_stb is high, so there is no ready on the result.
interface bf16_mul_pipe3_if;
  logic [2*bf16_mul_pipe3_pkg::DW-1:0] input_mul;
  logic                                input_mul_stb;
  logic                                s_input_mul_ack;
  logic [bf16_mul_pipe3_pkg::DW-1:0]   z;
  logic                                s_output_z_stb;

  modport master (
    output input_mul,
    output input_mul_stb,
    input  s_input_mul_ack,
    input  z,
    input  s_output_z_stb
  );

  modport slave (
    input  input_mul,
    input  input_mul_stb,
    output s_input_mul_ack,
    output z,
    output s_output_z_stb
  );
endinterface

// File: rtl/bf16_mul_pipe3_round_pack.sv
// Combinational normalize / round-to-nearest-even / range-check / pack of a bf16 product.
// Zero latency; special-case flags override the arithmetic path.
module bf16_round_pack
  import bf16_mul_pipe3_pkg::*;
(
  input  logic              i_sign,
  input  logic [SEXP_W-1:0] i_exp,
  input  logic [15:0]       i_prod,
  input  logic              i_nan,
  input  logic              i_inf,
  input  logic              i_zero,
  output logic [DW-1:0]     o_z
);

  logic [MAN_W-1:0]         w_frac;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_rnd;
  logic [MAN_W:0]           w_sum;
  logic signed [SEXP_W-1:0] w_exp_n;
  logic signed [SEXP_W-1:0] w_exp_f;

  always_comb begin
    w_frac   = i_prod[13:7];
    w_guard  = i_prod[6];
    w_sticky = |i_prod[5:0];
    w_exp_n  = $signed(i_exp);
    if (i_prod[15]) begin
      w_frac   = i_prod[14:8];
      w_guard  = i_prod[7];
      w_sticky = |i_prod[6:0];
      w_exp_n  = $signed(i_exp) + 10'sd1;
    end
    w_rnd   = w_guard & (w_sticky | w_frac[0]);
    // A carry out of the rounded fraction leaves it all-zero and bumps the exponent.
    w_sum   = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_rnd};
    w_exp_f = w_exp_n + $signed({{(SEXP_W-1){1'b0}}, w_sum[MAN_W]});

    o_z = {i_sign, w_exp_f[EXP_W-1:0], w_sum[MAN_W-1:0]};
    if (i_nan) begin
      o_z = QNAN;
    end else if (i_inf) begin
      o_z = INF | {i_sign, {(DW-1){1'b0}}};
    end else if (i_zero) begin
      o_z = {i_sign, {(DW-1){1'b0}}};
    end else if (w_exp_f >= 10'sd255) begin
      o_z = INF | {i_sign, {(DW-1){1'b0}}};
    end else if (w_exp_f <= 10'sd0) begin
      o_z = {i_sign, {(DW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/bf16_mul_pipe3.sv
// Pipelined bf16 multiplier: capture, unpack, 8x8 multiply, round/pack; result 3 cycles after capture.
// Always ready out of reset, no output back-pressure; one strobe per accepted pair, in order.
module bf16_mul_pipe3
  import bf16_mul_pipe3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  bf16_mul_pipe3_if.slave  io_mul
);

  logic            w_xfer;
  logic            r_in_vld;
  logic [2*DW-1:0] r_in_dat;
  s1_t             w_s1;
  s1_t             r_s1;
  s2_t             w_s2;
  s2_t             r_s2;
  logic [DW-1:0]   w_z;
  logic [DW-1:0]   r_z;
  logic            r_stb;

  assign io_mul.s_input_mul_ack = rst;
  assign w_xfer                 = io_mul.input_mul_stb & rst;

  assign w_s1 = unpack(r_in_vld, r_in_dat[2*DW-1:DW], r_in_dat[DW-1:0]);

  always_comb begin
    w_s2      = '0;
    w_s2.vld  = r_s1.vld;
    w_s2.sign = r_s1.sign;
    w_s2.exp  = r_s1.exp;
    w_s2.prod = r_s1.man_a * r_s1.man_b;
    w_s2.nan  = r_s1.nan;
    w_s2.inf  = r_s1.inf;
    w_s2.zero = r_s1.zero;
  end

  bf16_round_pack u_round_pack (
    .i_sign (r_s2.sign),
    .i_exp  (r_s2.exp),
    .i_prod (r_s2.prod),
    .i_nan  (r_s2.nan),
    .i_inf  (r_s2.inf),
    .i_zero (r_s2.zero),
    .o_z    (w_z)
  );

  // Reset clears every stage valid at once so in-flight products never strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_vld <= 1'b0;
      r_in_dat <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_stb    <= 1'b0;
      r_z      <= '0;
    end else begin
      r_in_vld <= w_xfer;
      if (w_xfer) begin
        r_in_dat <= io_mul.input_mul;
      end
      r_s1  <= w_s1;
      r_s2  <= w_s2;
      r_stb <= r_s2.vld;
      if (r_s2.vld) begin
        r_z <= w_z;
      end
    end
  end

  assign io_mul.z              = r_z;
  assign io_mul.s_output_z_stb = r_stb;

endmodule

// File: tb/tb_bf16_mul_pipe3.sv
// Directed and randomized checks of bf16_mul_pipe3 against a real-arithmetic reference model.
module tb_bf16_mul_pipe3;
  import bf16_mul_pipe3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bf16_mul_pipe3_if bus ();

  bf16_mul_pipe3 dut (
    .clk    (clk),
    .rst    (rst),
    .io_mul (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact product of the operand values, then RNE to 8 significant bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int   ea, eb, ma, mb, e, ip, be;
    bit   an, bn, ai, bi, az, bz;
    real  m, sc, fr;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = int'(a[6:0]);
    mb = int'(b[6:0]);
    an = (ea == 255) && (ma != 0);
    bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0);
    bi = (eb == 255) && (mb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return 16'h7FC0;
    if (ai || bi) return {s, 8'hFF, 7'h00};
    if (az || bz) return {s, 15'h0000};
    m = (1.0 + real'(ma) / 128.0) * (1.0 + real'(mb) / 128.0);
    e = (ea - 127) + (eb - 127);
    while (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    sc = m * 128.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 256) begin
      ip = 128;
      e++;
    end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 7'h00};
    if (be <= 0) return {s, 15'h0000};
    return {s, be[7:0], ip[6:0]};
  endfunction

  function automatic logic [15:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return {1'($urandom), 8'($urandom_range(90, 165)), 7'($urandom)};
  endfunction

  // Entered just after a falling edge; leaves just after a falling edge with the pipe empty.
  task automatic apply_one(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_z, input string tag);
    bus.input_mul     = {a, b};
    bus.input_mul_stb = 1'b1;
    @(posedge clk);
    #1;
    bus.input_mul_stb = 1'b0;
    bus.input_mul     = 32'($urandom);
    @(posedge clk);
    #1 chk({tag, "_stb_n1"}, 16'(bus.s_output_z_stb), 16'd0);
    @(posedge clk);
    #1 chk({tag, "_stb_n2"}, 16'(bus.s_output_z_stb), 16'd0);
    @(posedge clk);
    #1 chk({tag, "_stb_n3"}, 16'(bus.s_output_z_stb), 16'd1);
    chk({tag, "_z"}, bus.z, exp_z);
    @(posedge clk);
    #1 chk({tag, "_stb_n4"}, 16'(bus.s_output_z_stb), 16'd0);
    @(negedge clk);
  endtask

  logic [15:0] a_q [32];
  logic [15:0] b_q [32];

  initial begin
    rst               = 1'b0;
    bus.input_mul     = '0;
    bus.input_mul_stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stb", 16'(bus.s_output_z_stb), 16'd0);
    chk("rst_z", bus.z, 16'h0000);
    chk("rst_ack", 16'(bus.s_input_mul_ack), 16'd0);
    rst = 1'b1;
    #1 chk("ack_after_rst", 16'(bus.s_input_mul_ack), 16'd1);
    @(negedge clk);

    apply_one(16'h3F80, 16'h3F80, 16'h3F80, "one_x_one");
    apply_one(16'h4000, 16'h4040, 16'h40C0, "two_x_three");
    apply_one(16'hBFC0, 16'h4000, 16'hC040, "neg_sign");
    apply_one(16'h3F81, 16'h3F81, 16'h3F82, "rne_no_tie");
    apply_one(16'h7F80, 16'h0000, 16'h7FC0, "inf_x_zero");
    apply_one(16'hFF80, 16'h4000, 16'hFF80, "ninf_x_two");
    apply_one(16'h7FC1, 16'h3F80, 16'h7FC0, "nan_in");
    apply_one(16'h8000, 16'h4000, 16'h8000, "neg_zero");
    apply_one(16'h0001, 16'h4000, 16'h0000, "subnorm_ftz");
    apply_one(16'h7F7F, 16'h7F7F, 16'h7F80, "overflow");
    apply_one(16'h0080, 16'h0080, 16'h0000, "underflow");

    for (int i = 0; i < 32; i++) begin
      a_q[i] = rand_operand();
      b_q[i] = rand_operand();
    end
    // Pair i is driven at falling edge i; its result is visible at falling edge i+4.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("strm_stb_%0d", k), 16'(bus.s_output_z_stb), 16'((k >= 4) && (k < 36)));
      if (k >= 4 && k < 36)
        chk($sformatf("strm_z_%0d", k - 4), bus.z, ref_mul(a_q[k-4], b_q[k-4]));
      if (k < 32) begin
        bus.input_mul     = {a_q[k], b_q[k]};
        bus.input_mul_stb = 1'b1;
      end else begin
        bus.input_mul_stb = 1'b0;
      end
    end

    @(negedge clk);
    bus.input_mul     = {16'h4000, 16'h4040};
    bus.input_mul_stb = 1'b1;
    @(negedge clk);
    bus.input_mul     = {16'h3F80, 16'h3F80};
    @(negedge clk);
    bus.input_mul_stb = 1'b0;
    rst               = 1'b0;
    #1;
    chk("midrst_stb", 16'(bus.s_output_z_stb), 16'd0);
    chk("midrst_z", bus.z, 16'h0000);
    chk("midrst_ack", 16'(bus.s_input_mul_ack), 16'd0);
    repeat (2) @(negedge clk);
    chk("midrst_hold_stb", 16'(bus.s_output_z_stb), 16'd0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 chk($sformatf("post_rst_idle_stb_%0d", k), 16'(bus.s_output_z_stb), 16'd0);
      chk($sformatf("post_rst_idle_z_%0d", k), bus.z, 16'h0000);
    end
    @(negedge clk);
    apply_one(16'h4000, 16'h4040, 16'h40C0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
